// File: rtl/sha_result_checker_pkg.sv
// Shared constants, state encoding and compare helper for the SHA result checker.
// Optional feature macro: SHA_CHECK_HASH_OUT_EN (widens FIFO entries to carry the hash).
package sha_result_checker_pkg;

    localparam int WORD_S    = 32;
    localparam int H_SIZE    = 256;
    localparam int NUM_WORDS = H_SIZE / WORD_S;

`ifdef SHA_CHECK_HASH_OUT_EN
    localparam int ENTRY_W = WORD_S + H_SIZE;
`else
    localparam int ENTRY_W = WORD_S;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Most-significant word decides first; a lower word only counts when every higher word is equal.
    function automatic logic lt_reduce(input logic [NUM_WORDS-1:0] lt,
                                       input logic [NUM_WORDS-1:0] eq);
        logic higher_eq;
        logic match;
        higher_eq = 1'b1;
        match     = 1'b0;
        for (int k = NUM_WORDS - 1; k >= 0; k--) begin
            if (higher_eq && lt[k]) match = 1'b1;
            higher_eq = higher_eq && eq[k];
        end
        return match;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags, flush, and simultaneous read/write when full.
// The head output reads 0 from reset or flush until the first write lands.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             wr_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             fresh;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A read in the same cycle frees the slot the write needs.
    assign do_wr   = wr_en && (!full || do_rd);
    assign wr_drop = wr_en && !do_wr;
    assign rd_data = fresh ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fresh  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fresh  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                fresh  <= 1'b0;
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is reset so a drained FIFO never exposes X on the head output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sha_result_checker.sv
// Checks pipeline hashes against a target, queues golden nonces, and hands them out over valid/ready.
// Optional feature macro: SHA_CHECK_HASH_OUT_EN (adds out_hash with the head entry's hash).
module sha_result_checker
    import sha_result_checker_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [H_SIZE-1:0] target,
    input  logic [WORD_S-1:0] last_nonce,
    input  logic              en,
    input  logic [WORD_S-1:0] nonce,
    input  logic [H_SIZE-1:0] H,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_S-1:0] out_nonce,
    output logic [CNT_W-1:0]  hash_count,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef SHA_CHECK_HASH_OUT_EN
    ,
    output logic [H_SIZE-1:0] out_hash
`endif
);

    state_t state;
    state_t next_state;

    logic                 start_run;
    logic                 accept;
    logic                 last_hit;
    logic [NUM_WORDS-1:0] h_lt;
    logic [NUM_WORDS-1:0] h_eq;

    logic                 s1_valid;
    logic [WORD_S-1:0]    s1_nonce;
    logic [NUM_WORDS-1:0] s1_lt;
    logic [NUM_WORDS-1:0] s1_eq;
    logic                 s2_valid;
    logic                 s2_match;
    logic [WORD_S-1:0]    s2_nonce;

    logic                 fifo_wr;
    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_drop;

    assign start_run = start && !clear && (state != ST_RUN);
    assign accept    = en && (state == ST_RUN);
    assign last_hit  = s2_valid && (s2_nonce == last_nonce) && (state == ST_RUN);

    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            h_lt[k] = H[k*WORD_S +: WORD_S] <  target[k*WORD_S +: WORD_S];
            h_eq[k] = H[k*WORD_S +: WORD_S] == target[k*WORD_S +: WORD_S];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (start)    next_state = ST_RUN;
                ST_RUN:  if (last_hit) next_state = ST_DONE;
                ST_DONE: if (start)    next_state = ST_RUN;
                default:               next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_nonce <= '0;
            s1_lt    <= '0;
            s1_eq    <= '0;
            s2_valid <= 1'b0;
            s2_match <= 1'b0;
            s2_nonce <= '0;
        end else begin
            s1_valid <= accept && !clear;
            s2_valid <= s1_valid && !clear;
            if (accept) begin
                s1_nonce <= nonce;
                s1_lt    <= h_lt;
                s1_eq    <= h_eq;
            end
            if (s1_valid) begin
                s2_nonce <= s1_nonce;
                s2_match <= lt_reduce(s1_lt, s1_eq);
            end
        end
    end

`ifdef SHA_CHECK_HASH_OUT_EN
    logic [H_SIZE-1:0] s1_hash;
    logic [H_SIZE-1:0] s2_hash;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_hash <= '0;
            s2_hash <= '0;
        end else begin
            if (accept)   s1_hash <= H;
            if (s1_valid) s2_hash <= s1_hash;
        end
    end

    assign fifo_wdata = {s2_hash, s2_nonce};
    assign out_hash   = fifo_rdata[ENTRY_W-1 -: H_SIZE];
`else
    assign fifo_wdata = s2_nonce;
`endif

    // Matches land regardless of state so in-flight results still arrive after DONE.
    assign fifo_wr = s2_valid && s2_match && !clear;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (clear),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (out_ready),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .wr_drop (fifo_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hash_count <= '0;
            overflow   <= 1'b0;
        end else if (clear || start_run) begin
            hash_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (s2_valid && (state == ST_RUN) && (hash_count != '1))
                hash_count <= hash_count + 1'b1;
            if (fifo_drop) overflow <= 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_nonce = fifo_rdata[WORD_S-1:0];
    assign busy      = (state == ST_RUN) || s1_valid || s2_valid;
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_sha_result_checker.sv
// Directed self-checking bench for sha_result_checker.
// Optional feature macro: SHA_CHECK_HASH_OUT_EN (enables the out_hash check).
module tb_sha_result_checker;

    localparam logic [255:0] TGT    = {32'h0, {224{1'b1}}};
    localparam logic [255:0] TGT_M1 = {32'h0, {223{1'b1}}, 1'b0};
    localparam logic [255:0] H_MISS = {32'hFFFF_FFFF, 224'h0};
    localparam logic [255:0] H_HIT  = {32'h0, 224'h1234};
    localparam logic [255:0] H_SEV  = {32'h0, 32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF,
                                       32'hCAFE_F00D, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         clear = 1'b0;
    logic [255:0] target = '0;
    logic [31:0]  last_nonce = '0;
    logic         en = 1'b0;
    logic [31:0]  nonce = '0;
    logic [255:0] H = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_nonce;
    logic [47:0]  hash_count;
    logic         busy;
    logic         done;
    logic         overflow;
`ifdef SHA_CHECK_HASH_OUT_EN
    logic [255:0] out_hash;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha_result_checker #(.FIFO_DEPTH(8), .CNT_W(48)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .target     (target),
        .last_nonce (last_nonce),
        .en         (en),
        .nonce      (nonce),
        .H          (H),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nonce  (out_nonce),
        .hash_count (hash_count),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
`ifdef SHA_CHECK_HASH_OUT_EN
        ,
        .out_hash   (out_hash)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear_start(input logic [31:0] last);
        last_nonce = last;
        clear = 1'b1; step(); clear = 1'b0;
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_nonce !== 32'h0) begin errors++; $display("FAIL reset_out_nonce: got %h want 0", out_nonce); end
        checks++; if (hash_count !== 48'h0) begin errors++; $display("FAIL reset_hash_count: got %0d want 0", hash_count); end
        checks++; if ({busy, done, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, overflow}); end
        @(negedge clk); reset = 1'b1;
        step();
    endtask

    task automatic test_basic_run();
        target = TGT;
        do_clear_start(32'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_run: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; nonce = 32'(i); H = (i == 2) ? H_HIT : H_MISS;
            step();
            if (i >= 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid_%0d: got %b want 0", i, out_valid); end
            end
        end
        en = 1'b0; step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid: got %b want 1", out_valid); end
        checks++; if (out_nonce !== 32'h2) begin errors++; $display("FAIL basic_out_nonce: got %h want 2", out_nonce); end
        step(); step();
        checks++; if (hash_count !== 48'd4) begin errors++; $display("FAIL basic_hash_count: got %0d want 4", hash_count); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_equal_target();
        target = TGT;
        last_nonce = 32'd6;
        clear = 1'b1; step(); clear = 1'b0;
        checks++; if (out_nonce !== 32'h0) begin errors++; $display("FAIL eq_clear_nonce: got %h want 0", out_nonce); end
        start = 1'b1; step(); start = 1'b0;
        en = 1'b1; nonce = 32'd5; H = TGT; step();
        nonce = 32'd6; H = TGT_M1; step();
        en = 1'b0; step(); step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL eq_valid: got %b want 1", out_valid); end
        checks++; if (out_nonce !== 32'd6) begin errors++; $display("FAIL eq_out_nonce: got %0d want 6", out_nonce); end
        checks++; if (hash_count !== 48'd2) begin errors++; $display("FAIL eq_hash_count: got %0d want 2", hash_count); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eq_single_entry: got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        target = TGT;
        do_clear_start(32'd18);
        for (int i = 0; i < 9; i++) begin
            en = 1'b1; nonce = 32'(10 + i); H = H_HIT; step();
        end
        en = 1'b0; step(); step(); step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b want 1", done); end
        checks++; if (hash_count !== 48'd9) begin errors++; $display("FAIL ovf_hash_count: got %0d want 9", hash_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({out_valid, out_nonce} !== {1'b1, 32'(10 + i)}) begin
                errors++; $display("FAIL ovf_drain_%0d: got valid=%b nonce=%0d want valid=1 nonce=%0d", i, out_valid, out_nonce, 10 + i);
            end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_full_read_write();
        target = TGT;
        do_clear_start(32'd28);
        for (int i = 0; i < 9; i++) begin
            en = 1'b1; nonce = 32'(20 + i); H = H_HIT; step();
        end
        en = 1'b0; step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf_before: got %b want 0", overflow); end
        checks++; if (out_nonce !== 32'd20) begin errors++; $display("FAIL frw_head: got %0d want 20", out_nonce); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf_after: got %b want 0", overflow); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL frw_done: got %b want 1", done); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({out_valid, out_nonce} !== {1'b1, 32'(21 + i)}) begin
                errors++; $display("FAIL frw_drain_%0d: got valid=%b nonce=%0d want valid=1 nonce=%0d", i, out_valid, out_nonce, 21 + i);
            end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frw_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_run();
        target = TGT;
        do_clear_start(32'd40);
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; nonce = 32'(30 + i); H = H_HIT; step();
        end
        en = 1'b0; step(); step(); step();
        checks++; if ({out_valid, hash_count} !== {1'b1, 48'd3}) begin errors++; $display("FAIL rmr_queued: got valid=%b count=%0d want valid=1 count=3", out_valid, hash_count); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({out_valid, out_nonce} !== 33'h0) begin errors++; $display("FAIL rmr_out: got valid=%b nonce=%h want 0", out_valid, out_nonce); end
        checks++; if (hash_count !== 48'h0) begin errors++; $display("FAIL rmr_count: got %0d want 0", hash_count); end
        checks++; if ({busy, done, overflow} !== 3'b000) begin errors++; $display("FAIL rmr_flags: got %b want 000", {busy, done, overflow}); end
        @(negedge clk); reset = 1'b1;
        step();
        en = 1'b1; nonce = 32'd40; H = H_HIT; step();
        en = 1'b0; step(); step(); step();
        checks++; if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL rmr_idle_ignores_en: got %b want 000", {out_valid, busy, done}); end
        start = 1'b1; clear = 1'b1; step(); start = 1'b0; clear = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_beats_start: got busy=%b want 0", busy); end
        en = 1'b1; nonce = 32'd41; H = H_HIT; step();
        en = 1'b0; step(); step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_beats_start_fifo: got %b want 0", out_valid); end
    endtask

`ifdef SHA_CHECK_HASH_OUT_EN
    task automatic test_hash_out();
        target = TGT;
        do_clear_start(32'd7);
        en = 1'b1; nonce = 32'd7; H = H_SEV; step();
        en = 1'b0; H = H_MISS; step(); step(); step();
        checks++; if (out_hash !== H_SEV) begin errors++; $display("FAIL hash_out: got %h want %h", out_hash, H_SEV); end
        checks++; if (out_nonce !== 32'd7) begin errors++; $display("FAIL hash_out_nonce: got %0d want 7", out_nonce); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_run();
        test_equal_target();
        test_overflow();
        test_full_read_write();
        test_reset_mid_run();
`ifdef SHA_CHECK_HASH_OUT_EN
        test_hash_out();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
